// File: rtl/qarctan_prep_if.sv
// Stream bundle for qarctan_prep: FWFT I/Q input FIFOs plus the
// dividend, divisor and quadrant-flag output FIFOs.
interface qarctan_prep_if #(
  parameter int WIDTH = 32
);
  logic                    in_real_rd_en;
  logic                    in_real_empty;
  logic signed [WIDTH-1:0] in_real_dout;
  logic                    in_imag_rd_en;
  logic                    in_imag_empty;
  logic signed [WIDTH-1:0] in_imag_dout;
  logic                    outA_wr_en;
  logic                    outA_full;
  logic signed [WIDTH-1:0] outA_din;
  logic                    outB_wr_en;
  logic                    outB_full;
  logic signed [WIDTH-1:0] outB_din;
  logic                    flag_wr_en;
  logic                    flag_full;
  logic [1:0]              flag_din;

  modport master (
    output in_real_rd_en, in_imag_rd_en,
    output outA_wr_en, outA_din, outB_wr_en, outB_din, flag_wr_en, flag_din,
    input  in_real_empty, in_real_dout, in_imag_empty, in_imag_dout,
    input  outA_full, outB_full, flag_full
  );

  modport slave (
    input  in_real_rd_en, in_imag_rd_en,
    input  outA_wr_en, outA_din, outB_wr_en, outB_din, flag_wr_en, flag_din,
    output in_real_empty, in_real_dout, in_imag_empty, in_imag_dout,
    output outA_full, outB_full, flag_full
  );
endinterface

// File: rtl/qarctan_prep.sv
// FM demod front end: forms cur * conj(prev), then the qarctan dividend/divisor
// pair and quadrant flags, and pushes all three into their FIFOs together.
module qarctan_prep #(
  parameter int BITS  = 10,
  parameter int WIDTH = 32
) (
  input  logic          clock,
  input  logic          reset,
  qarctan_prep_if.master bus
);

  localparam int P_W = 2 * WIDTH;
  localparam logic signed [P_W-1:0]   QM1 = {{(P_W-BITS){1'b0}}, {BITS{1'b1}}};
  localparam logic signed [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_SUM, S_PREP, S_OUT} state_t;

  state_t r_state, w_next;
  logic   w_pop, w_push;

  logic signed [WIDTH-1:0] r_cur_real, r_cur_imag;
  logic signed [WIDTH-1:0] r_prev_real, r_prev_imag;
  logic signed [P_W-1:0]   r_p_rr, r_p_ii, r_p_ri, r_p_ir;
  logic signed [WIDTH-1:0] r_x, r_y;
  logic signed [WIDTH-1:0] r_dividend, r_divisor;
  logic [1:0]              r_flags;

  logic signed [WIDTH-1:0] w_abs_y, w_num, w_den;

  // Dequantize by QUANT with truncation toward zero, keeping the low WIDTH bits.
  function automatic logic signed [WIDTH-1:0] deq(input logic signed [P_W-1:0] p);
    logic signed [P_W-1:0] t;
    t = p[P_W-1] ? (p + QM1) : p;
    return WIDTH'(t >>> BITS);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // reset gates the pop so nothing leaves the input FIFOs while it is held
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_push = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!reset && !bus.in_real_empty && !bus.in_imag_empty) begin
          w_pop  = 1'b1;
          w_next = S_MUL;
        end
      end
      S_MUL:  w_next = S_SUM;
      S_SUM:  w_next = S_PREP;
      S_PREP: w_next = S_OUT;
      S_OUT: begin
        if (!bus.outA_full && !bus.outB_full && !bus.flag_full) begin
          w_push = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_abs_y = (r_y[WIDTH-1] ? -r_y : r_y) + ONE;
    if (!r_x[WIDTH-1]) begin
      w_num = r_x - w_abs_y;
      w_den = r_x + w_abs_y;
    end else begin
      w_num = r_x + w_abs_y;
      w_den = w_abs_y - r_x;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cur_real  <= '0;
      r_cur_imag  <= '0;
      r_prev_real <= '0;
      r_prev_imag <= '0;
      r_p_rr      <= '0;
      r_p_ii      <= '0;
      r_p_ri      <= '0;
      r_p_ir      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_flags     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_cur_real <= bus.in_real_dout;
            r_cur_imag <= bus.in_imag_dout;
          end
        end
        // cur * conj(prev): real = rr + ii, imag = ri - ir
        S_MUL: begin
          r_p_rr      <= P_W'(r_prev_real) * P_W'(r_cur_real);
          r_p_ii      <= P_W'(r_prev_imag) * P_W'(r_cur_imag);
          r_p_ri      <= P_W'(r_prev_real) * P_W'(r_cur_imag);
          r_p_ir      <= P_W'(r_prev_imag) * P_W'(r_cur_real);
          r_prev_real <= r_cur_real;
          r_prev_imag <= r_cur_imag;
        end
        S_SUM: begin
          r_x <= deq(r_p_rr) + deq(r_p_ii);
          r_y <= deq(r_p_ri) - deq(r_p_ir);
        end
        S_PREP: begin
          r_dividend <= w_num <<< BITS;
          r_divisor  <= w_den;
          r_flags    <= {r_x[WIDTH-1], r_y[WIDTH-1]};
        end
        default: ;
      endcase
    end
  end

  assign bus.in_real_rd_en = w_pop;
  assign bus.in_imag_rd_en = w_pop;
  assign bus.outA_wr_en    = w_push;
  assign bus.outB_wr_en    = w_push;
  assign bus.flag_wr_en    = w_push;
  assign bus.outA_din      = w_push ? r_dividend : '0;
  assign bus.outB_din      = w_push ? r_divisor  : '0;
  assign bus.flag_din      = w_push ? r_flags    : 2'b00;

endmodule
